idma_txrx_read: RTL and testbench



---
 rtl/idma_txrx_pkg.sv | 59 +++++
 rtl/idma_txrx_read.sv | 109 ++++++++++
 tb/tb_idma_txrx_read.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/idma_txrx_pkg.sv
// rtl/idma_txrx_pkg.sv - shared types, response codes and byte-mask helper for the TXRX read port
package idma_txrx_pkg;

  localparam int unsigned StrbWidth   = 4;
  localparam int unsigned OffsetWidth = $clog2(StrbWidth);

  typedef logic [7:0]             byte_t;
  typedef logic [StrbWidth-1:0]   strb_t;
  typedef logic [31:0]            addr_t;
  typedef logic [StrbWidth*8-1:0] data_t;
  typedef logic [1:0]             resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [OffsetWidth-1:0] offset;
    logic [OffsetWidth-1:0] tailer;
    logic [OffsetWidth-1:0] shift;
  } r_dp_req_t;

  typedef struct packed {
    resp_t resp;
    logic  first;
    logic  last;
  } r_dp_rsp_t;

  typedef struct packed {
    addr_t addr;
  } txrx_req_t;

  typedef struct packed {
    txrx_req_t txrx_req;
  } read_meta_chan_t;

  typedef struct packed {
    logic  req;
    addr_t addr;
    logic  rready;
  } read_req_t;

  typedef struct packed {
    logic  gnt;
    logic  rvalid;
    data_t rdata;
    logic  err;
  } read_rsp_t;

  // Bytes below offset and the top tailer bytes of a beat are not part of the transfer.
  function automatic strb_t calc_mask(input logic [OffsetWidth-1:0] offset,
                                      input logic [OffsetWidth-1:0] tailer);
    strb_t m;
    for (int unsigned i = 0; i < StrbWidth; i++) begin
      m[i] = (i >= 32'(offset)) && (i < (StrbWidth - 32'(tailer)));
    end
    return m;
  endfunction

endpackage

// File: rtl/idma_txrx_read.sv
// rtl/idma_txrx_read.sv - iDMA read port sourcing beats from a TXRX receive interface
// Optional feature macro IDMA_TXRX_READ_ERR_EN: forward read_rsp_i.err as a SLVERR response.
module idma_txrx_read
  import idma_txrx_pkg::*;
#(
  parameter int unsigned NumAxInFlight = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  r_dp_req_t                  r_dp_req_i,
  input  logic                       r_dp_valid_i,
  output logic                       r_dp_ready_o,
  output r_dp_rsp_t                  r_dp_rsp_o,
  output logic                       r_dp_valid_o,
  input  logic                       r_dp_ready_i,
  input  read_meta_chan_t            read_meta_req_i,
  input  logic                       read_meta_valid_i,
  output logic                       read_meta_ready_o,
  output read_req_t                  read_req_o,
  input  read_rsp_t                  read_rsp_i,
  output logic                       r_chan_valid_o,
  output logic                       r_chan_ready_o,
  output byte_t [StrbWidth-1:0]      buffer_in_o,
  output strb_t                      buffer_in_valid_o,
  input  strb_t                      buffer_in_ready_i
);

  localparam int unsigned CntWidth = $clog2(NumAxInFlight + 1);

  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] w_cnt_next;
  logic                r_rsp_valid;
  r_dp_rsp_t           r_rsp;
  logic                r_busy;

  logic  w_req;
  logic  w_grant;
  logic  w_rsp_free;
  logic  w_beat_ok;
  logic  w_rready;
  logic  w_beat;
  strb_t w_mask;
  resp_t w_resp;
  logic  w_unused;

  assign w_req      = read_meta_valid_i & (r_cnt < CntWidth'(NumAxInFlight));
  assign w_grant    = w_req & read_rsp_i.gnt;
  assign w_mask     = calc_mask(r_dp_req_i.offset, r_dp_req_i.tailer);
  assign w_rsp_free = ~r_rsp_valid | r_dp_ready_i;
  // Bytes outside the mask never block the beat; all masked bytes must land together.
  assign w_beat_ok  = &(buffer_in_ready_i | ~w_mask);
  assign w_rready   = r_dp_valid_i & w_rsp_free & w_beat_ok;
  assign w_beat     = read_rsp_i.rvalid & w_rready;

`ifdef IDMA_TXRX_READ_ERR_EN
  assign w_resp = read_rsp_i.err ? RESP_SLVERR : RESP_OKAY;
`else
  assign w_resp = RESP_OKAY;
`endif

  assign w_unused = ^{r_dp_req_i.shift, read_rsp_i.err};

  assign read_req_o.req    = w_req;
  assign read_req_o.addr   = read_meta_req_i.txrx_req.addr;
  assign read_req_o.rready = w_rready;
  assign read_meta_ready_o = w_grant;

  assign buffer_in_o       = read_rsp_i.rdata;
  assign buffer_in_valid_o = w_mask & {StrbWidth{read_rsp_i.rvalid & r_dp_valid_i & w_rsp_free}};
  assign r_dp_ready_o      = w_beat;
  assign r_chan_valid_o    = read_rsp_i.rvalid;
  assign r_chan_ready_o    = w_rready;
  assign r_dp_valid_o      = r_rsp_valid;
  assign r_dp_rsp_o        = r_rsp;

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_grant && !w_beat) begin
      w_cnt_next = r_cnt + CntWidth'(1);
    end else if (!w_grant && w_beat) begin
      w_cnt_next = r_cnt - CntWidth'(1);
    end
  end

  // r_busy marks an open burst so the next accepted beat after an idle period is flagged first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_beat) begin
        r_rsp_valid <= 1'b1;
        r_rsp.resp  <= w_resp;
        r_rsp.first <= ~r_busy;
        r_rsp.last  <= (w_cnt_next == '0);
        r_busy      <= (w_cnt_next != '0);
      end else if (r_dp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // A returned beat with nothing outstanding means the TXRX side broke protocol.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(read_rsp_i.rvalid && (r_cnt == '0)));

endmodule

// File: tb/tb_idma_txrx_read.sv
// tb/tb_idma_txrx_read.sv - self-checking bench for idma_txrx_read
module tb_idma_txrx_read;
  import idma_txrx_pkg::*;

  localparam int NumAx = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  r_dp_req_t             r_dp_req_i;
  logic                  r_dp_valid_i;
  logic                  r_dp_ready_o;
  r_dp_rsp_t             r_dp_rsp_o;
  logic                  r_dp_valid_o;
  logic                  r_dp_ready_i;
  read_meta_chan_t       read_meta_req_i;
  logic                  read_meta_valid_i;
  logic                  read_meta_ready_o;
  read_req_t             read_req_o;
  read_rsp_t             read_rsp_i;
  logic                  r_chan_valid_o;
  logic                  r_chan_ready_o;
  byte_t [StrbWidth-1:0] buffer_in_o;
  strb_t                 buffer_in_valid_o;
  strb_t                 buffer_in_ready_i;

  idma_txrx_read #(.NumAxInFlight(NumAx)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .r_dp_req_i(r_dp_req_i), .r_dp_valid_i(r_dp_valid_i), .r_dp_ready_o(r_dp_ready_o),
    .r_dp_rsp_o(r_dp_rsp_o), .r_dp_valid_o(r_dp_valid_o), .r_dp_ready_i(r_dp_ready_i),
    .read_meta_req_i(read_meta_req_i), .read_meta_valid_i(read_meta_valid_i),
    .read_meta_ready_o(read_meta_ready_o), .read_req_o(read_req_o), .read_rsp_i(read_rsp_i),
    .r_chan_valid_o(r_chan_valid_o), .r_chan_ready_o(r_chan_ready_o),
    .buffer_in_o(buffer_in_o), .buffer_in_valid_o(buffer_in_valid_o),
    .buffer_in_ready_i(buffer_in_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_cnt    = 0;
  bit         m_idle   = 1'b1;
  bit         m_rsp_valid = 1'b0;
  logic [3:0] m_rsp    = 4'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mask_of(input int o, input int t);
    return 4'(((1 << (4 - t)) - 1) & ~((1 << o) - 1));
  endfunction

  task automatic drv(input bit mv, input bit gnt, input bit rv, input bit err, input bit dv,
                     input int off, input int tail, input logic [3:0] bir, input bit rdr);
    read_meta_valid_i             = mv;
    read_meta_req_i.txrx_req.addr = $urandom;
    read_rsp_i.gnt                = gnt;
    read_rsp_i.rvalid             = rv;
    read_rsp_i.rdata              = $urandom;
    read_rsp_i.err                = err;
    r_dp_valid_i                  = dv;
    r_dp_req_i.offset             = 2'(off);
    r_dp_req_i.tailer             = 2'(tail);
    r_dp_req_i.shift              = 2'($urandom_range(0, 3));
    buffer_in_ready_i             = bir;
    r_dp_ready_i                  = rdr;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 4'h0, 1);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idle = 1'b1; m_rsp_valid = 1'b0; m_rsp = 4'h0;
  endtask

  // Checks one cycle against the reference rules, updates the model, advances to posedge+1.
  task automatic step();
    logic [3:0] mask, biv;
    logic [1:0] resp;
    bit         free, rdy, beat, grant, req, last;
    int         after;
    mask  = mask_of(int'(r_dp_req_i.offset), int'(r_dp_req_i.tailer));
    req   = read_meta_valid_i && (m_cnt < NumAx);
    grant = req && read_rsp_i.gnt;
    free  = !m_rsp_valid || r_dp_ready_i;
    rdy   = r_dp_valid_i && free && ((buffer_in_ready_i & mask) == mask);
    beat  = read_rsp_i.rvalid && rdy;
    biv   = (read_rsp_i.rvalid && r_dp_valid_i && free) ? mask : 4'h0;
`ifdef IDMA_TXRX_READ_ERR_EN
    resp = read_rsp_i.err ? 2'b10 : 2'b00;
`else
    resp = 2'b00;
`endif
    #1;
    check("req", 64'(read_req_o.req), 64'(req));
    check("addr", 64'(read_req_o.addr), 64'(read_meta_req_i.txrx_req.addr));
    check("meta_ready", 64'(read_meta_ready_o), 64'(grant));
    check("rready", 64'(read_req_o.rready), 64'(rdy));
    check("chan_ready", 64'(r_chan_ready_o), 64'(rdy));
    check("chan_valid", 64'(r_chan_valid_o), 64'(read_rsp_i.rvalid));
    check("dp_ready", 64'(r_dp_ready_o), 64'(beat));
    check("buf_valid", 64'(buffer_in_valid_o), 64'(biv));
    check("buf_data", 64'(buffer_in_o), 64'(read_rsp_i.rdata));
    check("rsp_valid", 64'(r_dp_valid_o), 64'(m_rsp_valid));
    if (m_rsp_valid) check("rsp", 64'(r_dp_rsp_o), 64'(m_rsp));
    if (beat) begin
      after = m_cnt - 1 + int'(grant);
      last  = (after == 0);
      m_rsp = {resp, m_idle, last};
      m_idle = last;
      m_rsp_valid = 1'b1;
    end else if (r_dp_ready_i) begin
      m_rsp_valid = 1'b0;
    end
    m_cnt = m_cnt + int'(grant) - int'(beat);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int o, t;
    rst_ni = 1'b0;
    idle();
    #1;
    check("reset_rsp_valid", 64'(r_dp_valid_o), 64'(0));
    check("reset_rsp", 64'(r_dp_rsp_o), 64'(0));
    check("reset_req", 64'(read_req_o.req), 64'(0));
    check("reset_buf_valid", 64'(buffer_in_valid_o), 64'(0));
    check("reset_dp_ready", 64'(r_dp_ready_o), 64'(0));
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single full beat
    drv(1, 1, 0, 0, 0, 0, 0, 4'h0, 1); step();
    drv(0, 0, 1, 0, 1, 0, 0, 4'hF, 1);
    read_rsp_i.rdata = 32'hDEADBEEF;
    #1 check("single_biv", 64'(buffer_in_valid_o), 64'(4'b1111));
    step();
    idle();
    #1 check("single_rsp_valid", 64'(r_dp_valid_o), 64'(1));
    check("single_rsp", 64'(r_dp_rsp_o), 64'(4'b0011));
    step();

    // Misaligned beat waits only on bytes 2:1
    drv(1, 1, 0, 0, 0, 0, 0, 4'h0, 1); step();
    drv(0, 0, 1, 0, 1, 1, 1, 4'b1001, 1);
    #1 check("mis_biv", 64'(buffer_in_valid_o), 64'(4'b0110));
    check("mis_hold", 64'(read_req_o.rready), 64'(0));
    step();
    drv(0, 0, 1, 0, 1, 1, 1, 4'b0110, 1);
    #1 check("mis_go", 64'(read_req_o.rready), 64'(1));
    step();
    idle(); step();

    // Outstanding limit
    drv(1, 1, 0, 0, 0, 0, 0, 4'h0, 1); step();
    drv(1, 1, 0, 0, 0, 0, 0, 4'h0, 1); step();
    drv(1, 1, 0, 0, 0, 0, 0, 4'h0, 1);
    #1 check("limit_req", 64'(read_req_o.req), 64'(0));
    step();
    drv(1, 1, 1, 0, 1, 0, 0, 4'hF, 1); step();
    drv(1, 1, 0, 0, 0, 0, 0, 4'h0, 1);
    #1 check("limit_reopen", 64'(read_req_o.req), 64'(1));
    step();
    drv(0, 0, 1, 0, 1, 0, 0, 4'hF, 1); step();
    drv(0, 0, 1, 0, 1, 0, 0, 4'hF, 1); step();
    idle(); step();

    // Response backpressure
    drv(1, 1, 0, 0, 0, 0, 0, 4'h0, 1); step();
    drv(1, 1, 0, 0, 0, 0, 0, 4'h0, 1); step();
    drv(0, 0, 1, 0, 1, 0, 0, 4'hF, 0); step();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 0, 1, 0, 0, 4'hF, 0);
      #1 check("bp_stall", 64'(read_req_o.rready), 64'(0));
      step();
    end
    drv(0, 0, 1, 0, 1, 0, 0, 4'hF, 1);
    #1 check("bp_release", 64'(read_req_o.rready), 64'(1));
    step();
    idle(); step();

    // Error on beat 2 of 3, one beat per cycle
    drv(1, 1, 0, 0, 0, 0, 0, 4'h0, 1); step();
    drv(1, 1, 1, 0, 1, 0, 0, 4'hF, 1); step();
    drv(1, 1, 1, 1, 1, 0, 0, 4'hF, 1); step();
    drv(0, 0, 1, 0, 1, 0, 0, 4'hF, 1);
`ifdef IDMA_TXRX_READ_ERR_EN
    #1 check("err_beat2", 64'(r_dp_rsp_o.resp), 64'(2'b10));
`else
    #1 check("err_beat2", 64'(r_dp_rsp_o.resp), 64'(2'b00));
`endif
    step();
    idle(); step();

    // Reset mid-transfer with two outstanding and a response pending
    drv(1, 1, 0, 0, 0, 0, 0, 4'h0, 1); step();
    drv(1, 1, 1, 0, 1, 0, 0, 4'hF, 0); step();
    drv(1, 1, 0, 0, 0, 0, 0, 4'h0, 0); step();
    idle();
    read_meta_valid_i = 1'b1;
    r_dp_ready_i = 1'b0;
    #1 check("pre_rst_req", 64'(read_req_o.req), 64'(0));
    check("pre_rst_valid", 64'(r_dp_valid_o), 64'(1));
    rst_ni = 1'b0;
    #1 check("rst_valid", 64'(r_dp_valid_o), 64'(0));
    check("rst_cnt_req", 64'(read_req_o.req), 64'(1));
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle(); step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      o = $urandom_range(0, 3);
      t = $urandom_range(0, 3 - o);
      drv(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
          (m_cnt > 0) && ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) != 0), o, t,
          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF, ($urandom_range(0, 3) != 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
